// File: rtl/fifo_rd_unpacker.sv
// Drains a sync_fifo read port and serialises each IN_WIDTH word into RATIO beats on a valid/ready stream.
// Optional: define UNPACK_MSB_FIRST_EN to emit the most significant slice first (default LSB-first).
module fifo_rd_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 send;
  logic                 last_beat;
  logic [OUT_WIDTH-1:0] beat [RATIO];

  // Beat k of the held word; the slice order is fixed here so the counter always runs 0..RATIO-1.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_beat
`ifdef UNPACK_MSB_FIRST_EN
      assign beat[gi] = word_q[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
`else
      assign beat[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
`endif
    end
  endgenerate

  assign send      = (state_q == SEND);
  assign last_beat = send && (cnt_q == CNT_LAST);

  assign busy    = send;
  assign m_valid = send;
  assign m_last  = last_beat;
  assign m_data  = send ? beat[cnt_q] : '0;

  // Pop when idle, or back-to-back with the accepted last beat so words stream without a bubble.
  assign fifo_pop = en_q && !fifo_empty && ((state_q == IDLE) || (m_ready && last_beat));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    en_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          word_d  = fifo_dout;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (last_beat) begin
            cnt_d = '0;
            if (fifo_pop) begin
              word_d = fifo_dout;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Scoreboard bench for fifo_rd_unpacker: a queue-based FIFO model feeds the DUT, a monitor checks every beat.
module tb_fifo_rd_unpacker;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int RT = IW / OW;

  logic          clk;
  logic          rstn;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [IW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;
  logic          busy;

  logic [IW-1:0] fq [$];
  logic [OW:0]   exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          pop_seen = 1'b0;

  fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue a word into the FIFO model and its beats (with the last flag) into the scoreboard.
  task automatic push_word(input logic [IW-1:0] w);
    logic [IW-1:0] tmp;
    fq.push_back(w);
    for (int k = 0; k < RT; k++) begin
      tmp = w;
`ifdef UNPACK_MSB_FIRST_EN
      tmp = tmp >> ((RT - 1 - k) * OW);
`else
      tmp = tmp >> (k * OW);
`endif
      exp_q.push_back({(k == RT - 1), tmp[OW-1:0]});
    end
    $display("push word %h", w);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk(nm, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
  endtask

  // FIFO model: outputs change 1 time unit after the falling edge; pops are sampled before the rising edge.
  initial begin
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (pop_seen && fq.size() > 0) void'(fq.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
      #3;
      pop_seen = fifo_pop;
    end
  end

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  initial begin
    logic [OW:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) chk("pop_when_empty", {31'd0, fifo_pop & fifo_empty}, 32'd0);
      if (rstn && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=%h last=%b exp data=%h last=%b", m_data, m_last, e[OW-1:0], e[OW]);
          chk("beat_data", {24'd0, m_data}, {24'd0, e[OW-1:0]});
          chk("beat_last", {31'd0, m_last}, {31'd0, e[OW]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn    = 1'b0;
    m_ready = 1'b1;
    push_word(32'hDDCC_BBAA);

    // Reset state with a non-empty FIFO
    repeat (3) @(negedge clk);
    #3;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data",  {24'd0, m_data},  32'd0);
    chk("rst_last",  {31'd0, m_last},  32'd0);
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_pop",   {31'd0, fifo_pop}, 32'd0);

    // Release: no pop in cycle 1, pop in cycle 2, valid in cycle 3
    @(negedge clk);
    rstn = 1'b1;
    #3;
    chk("t1_cyc1_pop", {31'd0, fifo_pop}, 32'd0);
    @(negedge clk); #3;
    chk("t1_cyc2_pop",   {31'd0, fifo_pop}, 32'd1);
    chk("t1_cyc2_valid", {31'd0, m_valid},  32'd0);
    @(negedge clk); #3;
    chk("t1_cyc3_valid", {31'd0, m_valid}, 32'd1);
    chk("t1_cyc3_busy",  {31'd0, busy},    32'd1);
    drain("t2_drain_idle");
    chk("t2_idle_valid", {31'd0, m_valid}, 32'd0);

    // Two words back to back: 8 beats with no bubble, second pop on the first word's last beat
    @(negedge clk);
    push_word(32'h0403_0201);
    push_word(32'h0807_0605);
    for (int i = 0; i < 2 * RT; i++) begin
      @(negedge clk); #3;
      chk("t3_no_bubble", {31'd0, m_valid}, 32'd1);
      chk("t3_pop_slot", {31'd0, fifo_pop}, {31'd0, (i == RT - 1)});
    end
    drain("t3_drain");

    // Stall on the second beat with another word waiting in the FIFO
    @(negedge clk);
    push_word(32'hDDCC_BBAA);
    @(negedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    push_word(32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      #3;
`ifdef UNPACK_MSB_FIRST_EN
      chk("t4_stall_data", {24'd0, m_data}, 32'h0000_00CC);
`else
      chk("t4_stall_data", {24'd0, m_data}, 32'h0000_00BB);
`endif
      chk("t4_stall_valid", {31'd0, m_valid}, 32'd1);
      chk("t4_stall_pop",   {31'd0, fifo_pop}, 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    drain("t4_drain");

    // Reset during beat 2 of 4: held word discarded, next word starts from beat 0
    @(negedge clk);
    push_word(32'hDDCC_BBAA);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    #3;
    chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_data",  {24'd0, m_data},  32'd0);
    chk("t5_rst_last",  {31'd0, m_last},  32'd0);
    chk("t5_rst_busy",  {31'd0, busy},    32'd0);
    push_word(32'h5566_7788);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    drain("t5_drain");

    @(negedge clk); #3;
    chk("end_fifo_empty", fq.size(), 32'd0);
    chk("end_scoreboard", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
